axi_lite_slave_regs: RTL and testbench

- AXI-Lite responder (slave) register bank; the completer for the core's AXI-Lite master port (m_axi_lite_*).
- Sits on the peripheral side of the interconnect and provides NUM_REGS 32-bit software-visible registers.
- Register 0 is a read-only ID; all other registers are read/write. All register contents are exported to fabric logic.
- Serves as the board-level control/status block and as a bench target for the core's MMIO path.

---
 rtl/axi_lite_slave_regs.sv | 140 ++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI-Lite register bank with read-only ID at register 0, exported contents and write pulses.
// Define AXIL_REGS_CYCLE_CNT_EN to make the highest register a free-running, loadable cycle counter.
module axi_lite_slave_regs #(
    parameter int          NUM_REGS   = 8,
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] ID_VALUE   = 32'h484F4C59
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              s_axi_lite_awaddr,
    input  logic                     s_axi_lite_awvalid,
    output logic                     s_axi_lite_awready,
    input  logic [31:0]              s_axi_lite_wdata,
    input  logic [3:0]               s_axi_lite_wstrb,
    input  logic                     s_axi_lite_wvalid,
    output logic                     s_axi_lite_wready,
    output logic [1:0]               s_axi_lite_bresp,
    output logic                     s_axi_lite_bvalid,
    input  logic                     s_axi_lite_bready,
    input  logic [31:0]              s_axi_lite_araddr,
    input  logic                     s_axi_lite_arvalid,
    output logic                     s_axi_lite_arready,
    output logic [31:0]              s_axi_lite_rdata,
    output logic [1:0]               s_axi_lite_rresp,
    output logic                     s_axi_lite_rvalid,
    input  logic                     s_axi_lite_rready,
    output logic [32*NUM_REGS-1:0]   regs_out,
    output logic [NUM_REGS-1:0]      wr_pulse
);
    localparam int IW = ADDR_WIDTH - 2;
    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;
    logic [31:0]         r_regs [NUM_REGS];
    logic                r_awready, r_wready, r_arready, r_aw_held, r_w_held;
    logic [IW-1:0]       r_awidx;
    logic [31:0]         r_wdata, r_rdata;
    logic [3:0]          r_wstrb;
    logic [1:0]          r_bresp, r_rresp;
    logic [NUM_REGS-1:0] r_wr_pulse;
    logic                w_aw_hs, w_w_hs, w_ar_hs, w_have_aw, w_have_w, w_commit;
    logic                w_aw_held_nxt, w_w_held_nxt, w_win, w_arin;
    logic [IW-1:0]       w_awidx, w_aridx, w_widx;
    logic [31:0]         w_wd, w_rd_val;
    logic [3:0]          w_ws;
    logic [NUM_REGS-1:0] w_hit;
    logic                w_unused;
    assign w_awidx  = s_axi_lite_awaddr[ADDR_WIDTH-1:2];
    assign w_aridx  = s_axi_lite_araddr[ADDR_WIDTH-1:2];
    assign w_unused = ^{s_axi_lite_awaddr[31:ADDR_WIDTH], s_axi_lite_awaddr[1:0],
                        s_axi_lite_araddr[31:ADDR_WIDTH], s_axi_lite_araddr[1:0]};
    // A beat arriving on the commit edge is used directly so AW+W together answer next cycle.
    always_comb begin
        w_aw_hs       = s_axi_lite_awvalid & r_awready;
        w_w_hs        = s_axi_lite_wvalid & r_wready;
        w_ar_hs       = s_axi_lite_arvalid & r_arready;
        w_have_aw     = r_aw_held | w_aw_hs;
        w_have_w      = r_w_held | w_w_hs;
        w_commit      = (r_wstate == W_IDLE) & w_have_aw & w_have_w;
        w_widx        = r_aw_held ? r_awidx : w_awidx;
        w_wd          = r_w_held ? r_wdata : s_axi_lite_wdata;
        w_ws          = r_w_held ? r_wstrb : s_axi_lite_wstrb;
        w_win         = int'(w_widx) < NUM_REGS;
        w_arin        = int'(w_aridx) < NUM_REGS;
        w_aw_held_nxt = w_have_aw & ~w_commit;
        w_w_held_nxt  = w_have_w & ~w_commit;
        w_wstate_nxt  = (r_wstate == W_IDLE) ? (w_commit ? W_RESP : W_IDLE)
                                             : (s_axi_lite_bready ? W_IDLE : W_RESP);
        w_rstate_nxt  = (r_rstate == R_IDLE) ? (w_ar_hs ? R_DATA : R_IDLE)
                                             : (s_axi_lite_rready ? R_IDLE : R_DATA);
        w_hit         = '0;
        w_rd_val      = '0;
        for (int i = 1; i < NUM_REGS; i++) w_hit[i] = w_commit & (w_widx == IW'(i));
        for (int i = 0; i < NUM_REGS; i++) if (w_aridx == IW'(i)) w_rd_val = r_regs[i];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_arready  <= 1'b0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awidx    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= '0;
            r_rresp    <= '0;
            r_rdata    <= '0;
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= (i == 0) ? ID_VALUE : 32'd0;
        end else begin
            r_awready  <= (w_wstate_nxt == W_IDLE) & ~w_aw_held_nxt;
            r_wready   <= (w_wstate_nxt == W_IDLE) & ~w_w_held_nxt;
            r_arready  <= w_rstate_nxt == R_IDLE;
            r_aw_held  <= w_aw_held_nxt;
            r_w_held   <= w_w_held_nxt;
            r_wr_pulse <= w_hit;
            if (w_aw_hs) r_awidx <= w_awidx;
            if (w_w_hs) begin
                r_wdata <= s_axi_lite_wdata;
                r_wstrb <= s_axi_lite_wstrb;
            end
            if (w_commit) r_bresp <= w_win ? 2'b00 : 2'b10;
            if (w_ar_hs) begin
                r_rdata <= w_rd_val;
                r_rresp <= w_arin ? 2'b00 : 2'b10;
            end
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_hit[i]) begin
                    for (int k = 0; k < 4; k++) if (w_ws[k]) r_regs[i][8*k +: 8] <= w_wd[8*k +: 8];
                end
`ifdef AXIL_REGS_CYCLE_CNT_EN
                else if (i == NUM_REGS - 1) r_regs[i] <= r_regs[i] + 32'd1;
`endif
            end
        end
    end
    assign s_axi_lite_awready = r_awready;
    assign s_axi_lite_wready  = r_wready;
    assign s_axi_lite_arready = r_arready;
    assign s_axi_lite_bvalid  = r_wstate == W_RESP;
    assign s_axi_lite_bresp   = r_bresp;
    assign s_axi_lite_rvalid  = r_rstate == R_DATA;
    assign s_axi_lite_rdata   = r_rdata;
    assign s_axi_lite_rresp   = r_rresp;
    assign wr_pulse           = r_wr_pulse;
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[32*g +: 32] = r_regs[g];
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: directed checks of the AXI-Lite register bank with hand-computed expectations.
module tb_axi_lite_slave_regs;
    localparam logic [31:0] ID = 32'h484F4C59;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;
    logic [255:0] regs_out;
    logic [7:0]   wr_pulse;
    int           n_pass = 0;
    int           n_total = 0;

    axi_lite_slave_regs dut (
        .clk(clk), .rst(rst),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
        .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid),
        .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid),
        .s_axi_lite_arready(arready), .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
        .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready),
        .regs_out(regs_out), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat, output logic [7:0] pulse);
        int t = 0;
        while (!(awready && wready) && t < 20) begin tick; t++; end
        if (t >= 20) begin
            n_total++;
            $display("FAIL write_ready_timeout: got awready=%b wready=%b required 1/1", awready, wready);
        end
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        pulse = wr_pulse;
        lat = 0;
        while (!bvalid && lat < 20) begin tick; lat++; end
        resp = bresp;
        tick;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int lat);
        int t = 0;
        while (!arready && t < 20) begin tick; t++; end
        if (t >= 20) begin
            n_total++;
            $display("FAIL read_ready_timeout: got arready=%b required 1", arready);
        end
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        tick;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin tick; lat++; end
        d = rdata; resp = rresp;
        tick;
        rready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        n_total++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0)
            $display("FAIL reset_handshake: got %b required 00000", {awready, wready, arready, bvalid, rvalid});
        else n_pass++;
        n_total++;
        if ({wr_pulse, bresp, rresp, rdata} !== 44'h0)
            $display("FAIL reset_outputs: got %h required 0", {wr_pulse, bresp, rresp, rdata});
        else n_pass++;
        n_total++;
        if (regs_out[255:32] !== 224'h0) $display("FAIL reset_regs: got %h required 0", regs_out[255:32]);
        else n_pass++;
        n_total++;
        if (regs_out[31:0] !== ID) $display("FAIL reset_id: got %h required %h", regs_out[31:0], ID);
        else n_pass++;
        rst = 1'b0;
        tick;
        n_total++;
        if ({awready, wready, arready} !== 3'b111)
            $display("FAIL ready_after_reset: got %b required 111", {awready, wready, arready});
        else n_pass++;
    endtask

    task automatic test_read_id;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_read(32'h0, d, r, lat);
        n_total++;
        if ({lat == 0, r, d} !== {1'b1, 2'b00, ID})
            $display("FAIL read_id: got lat=%0d resp=%b data=%h required lat=0 resp=00 data=%h", lat, r, d, ID);
        else n_pass++;
    endtask

    task automatic test_write_read;
        logic [31:0] d;
        logic [1:0]  r;
        logic [7:0]  p;
        int          lat;
        do_write(32'h4, 32'hDEADBEEF, 4'hF, r, lat, p);
        n_total++;
        if ({lat == 0, r} !== 3'b100) $display("FAIL write1_resp: got lat=%0d resp=%b required lat=0 resp=00", lat, r);
        else n_pass++;
        n_total++;
        if (p !== 8'h02) $display("FAIL write1_pulse: got %b required 00000010", p);
        else n_pass++;
        n_total++;
        if (wr_pulse !== 8'h00) $display("FAIL write1_pulse_width: got %b required 00000000", wr_pulse);
        else n_pass++;
        n_total++;
        if (regs_out[63:32] !== 32'hDEADBEEF) $display("FAIL write1_regs_out: got %h required deadbeef", regs_out[63:32]);
        else n_pass++;
        do_read(32'h4, d, r, lat);
        n_total++;
        if ({r, d} !== {2'b00, 32'hDEADBEEF}) $display("FAIL read1: got resp=%b data=%h required 00/deadbeef", r, d);
        else n_pass++;
    endtask

    task automatic test_strobe_order;
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b0;
        tick;
        wvalid = 1'b0;
        n_total++;
        if ({awready, wready} !== 2'b10) $display("FAIL w_first_readies: got %b required 10", {awready, wready});
        else n_pass++;
        tick; tick;
        awaddr = 32'h8; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        n_total++;
        if ({bvalid, bresp, wr_pulse} !== {1'b1, 2'b00, 8'h04})
            $display("FAIL late_aw_commit: got bvalid=%b bresp=%b pulse=%b required 1/00/00000100", bvalid, bresp, wr_pulse);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_total++;
            if ({bvalid, bresp, awready, wready} !== 5'b10000)
                $display("FAIL b_hold_%0d: got %b required 10000", i, {bvalid, bresp, awready, wready});
            else n_pass++;
        end
        n_total++;
        if (wr_pulse !== 8'h00) $display("FAIL strobe_pulse_width: got %b required 00000000", wr_pulse);
        else n_pass++;
        bready = 1'b1;
        tick;
        bready = 1'b0;
        n_total++;
        if ({bvalid, awready, wready} !== 3'b011) $display("FAIL after_b_hs: got %b required 011", {bvalid, awready, wready});
        else n_pass++;
        n_total++;
        if (regs_out[95:64] !== 32'h00220044) $display("FAIL strobe_value: got %h required 00220044", regs_out[95:64]);
        else n_pass++;
    endtask

    task automatic test_out_of_range;
        logic [31:0]  d;
        logic [1:0]   r;
        logic [7:0]   p;
        int           lat;
        logic [223:0] exp_regs;
        exp_regs = {32'h0, 32'h0, 32'h0, 32'h0, 32'h00220044, 32'hDEADBEEF, ID};
        do_write(32'h20, 32'hA5A5A5A5, 4'hF, r, lat, p);
        n_total++;
        if ({r, p} !== {2'b10, 8'h00}) $display("FAIL oor_write: got resp=%b pulse=%b required 10/00000000", r, p);
        else n_pass++;
        n_total++;
        if (regs_out[223:0] !== exp_regs) $display("FAIL oor_write_regs: got %h required %h", regs_out[223:0], exp_regs);
        else n_pass++;
        do_read(32'h3C, d, r, lat);
        n_total++;
        if ({r, d} !== {2'b10, 32'h0}) $display("FAIL oor_read: got resp=%b data=%h required 10/00000000", r, d);
        else n_pass++;
        do_write(32'h0, 32'h12345678, 4'hF, r, lat, p);
        n_total++;
        if ({r, p} !== {2'b00, 8'h00}) $display("FAIL id_write: got resp=%b pulse=%b required 00/00000000", r, p);
        else n_pass++;
        do_read(32'h0, d, r, lat);
        n_total++;
        if ({r, d} !== {2'b00, ID}) $display("FAIL id_after_write: got resp=%b data=%h required 00/%h", r, d, ID);
        else n_pass++;
        n_total++;
        if (regs_out[223:0] !== exp_regs) $display("FAIL id_write_regs: got %h required %h", regs_out[223:0], exp_regs);
        else n_pass++;
        do_read(32'h0000000B, d, r, lat);
        n_total++;
        if ({r, d} !== {2'b00, 32'h00220044}) $display("FAIL unaligned_read: got resp=%b data=%h required 00/00220044", r, d);
        else n_pass++;
        do_read(32'h10000004, d, r, lat);
        n_total++;
        if ({r, d} !== {2'b00, 32'hDEADBEEF}) $display("FAIL upper_bits_read: got resp=%b data=%h required 00/deadbeef", r, d);
        else n_pass++;
    endtask

    task automatic test_reset_midread;
        araddr = 32'h4; arvalid = 1'b1; rready = 1'b0;
        tick;
        arvalid = 1'b0;
        n_total++;
        if ({rvalid, rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL midread_data: got rvalid=%b data=%h required 1/deadbeef", rvalid, rdata);
        else n_pass++;
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_total++;
        if ({rvalid, arready, rdata} !== 34'h0) $display("FAIL midread_reset: got rvalid=%b arready=%b data=%h required 0/0/0", rvalid, arready, rdata);
        else n_pass++;
        n_total++;
        if (regs_out[63:32] !== 32'h0) $display("FAIL midread_reg1: got %h required 00000000", regs_out[63:32]);
        else n_pass++;
        tick;
        n_total++;
        if ({arready, rvalid} !== 2'b10) $display("FAIL midread_arready: got %b required 10", {arready, rvalid});
        else n_pass++;
    endtask

`ifdef AXIL_REGS_CYCLE_CNT_EN
    task automatic test_cycle_cnt;
        logic [31:0] d;
        logic [1:0]  r;
        logic [7:0]  p;
        int          lat;
        do_write(32'h1C, 32'hFFFFFFFE, 4'hF, r, lat, p);
        n_total++;
        if ({r, p} !== {2'b00, 8'h80}) $display("FAIL cnt_write: got resp=%b pulse=%b required 00/10000000", r, p);
        else n_pass++;
        tick; tick;
        do_read(32'h1C, d, r, lat);
        n_total++;
        if ({r, d} !== {2'b00, 32'h1}) $display("FAIL cnt_wrap: got resp=%b data=%h required 00/00000001", r, d);
        else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        test_reset;
        test_read_id;
        test_write_read;
        test_strobe_order;
        test_out_of_range;
        test_reset_midread;
`ifdef AXIL_REGS_CYCLE_CNT_EN
        test_cycle_cnt;
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
